execute_stage: RTL and testbench
================================

# execute_stage

Registered execute stage that consumes the decoded ALU operation and operand-source selections produced by ALU control. It resolves both operands, computes the ALU result and branch outcome, and presents them to the memory/writeback side through a valid/ready output register. Shifts run on an iterative 1-bit-per-cycle shifter unless the barrel shifter is compiled in. Instructions are accepted from decode with a valid/ready handshake, and the stage back-pressures decode while busy.

## Interface
- XLEN, 32, datapath width; shift amount is the low log2(XLEN) bits of operand 2
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  reset, synchronous, active-low
- valid_i  input  1  decode presents an instruction
- ready_o  output  1  stage can accept this cycle
- alu_op_i  input  alu_op_e  operation
- alu_src1_i, alu_src2_i  input  alu_src_e  operand selects
- rs1_data_i, rs2_data_i, imm_i, pc_i  input  XLEN  operand sources
- funct3_i  input  3  branch condition
- is_branch_i  input  1  branch instruction
- rd_addr_i  input  5  destination register
- rd_we_i  input  1  register write enable
- flush_i  input  1  kill in-flight and output instruction
- valid_o  output  1  result register holds an instruction
- ready_i  input  1  downstream accepts
- result_o  output  XLEN  ALU result
- rd_addr_o  output  5  registered rd_addr_i
- rd_we_o  output  1  registered rd_we_i
- branch_taken_o  output  1  branch condition true; 0 for non-branches

## Operation
- Operand mux (per source): REG gives rs1_data_i (src1) or rs2_data_i (src2); IMM gives imm_i; PC gives pc_i; ZERO gives 0.
- Accept when valid_i && ready_o.
- ready_o = (state == IDLE) && (!valid_o || ready_i) && !flush_i.
- Non-shift ops (ADD, SUB, AND, OR, XOR, SLT signed, SLTU unsigned):
  - Computed combinationally from the accepted operands.
  - Written to the output register on the accept edge.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Branch: branch_taken_o is evaluated from the operands, not from the ALU result:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 give not-taken.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: accepting a shift with shamt==0 completes like a non-shift op. Accepting a shift with shamt>0 latches operand, shamt, op and metadata, then goes to SHIFT.
  - SHIFT: one bit position per cycle. SRA replicates the sign bit. The counter decrements each cycle. When the counter reaches 1, write result_o, set valid_o, and go to HOLD if !ready_i is a risk. HOLD is entered only when the output register is still occupied.
  - HOLD: the finished result waits until the output register frees (!valid_o || ready_i), then writes and goes to IDLE.
- Output register: valid_o clears on ready_i && valid_o unless a new result is written in the same cycle. Simultaneous drain and refill is allowed and gives no bubble.
- flush_i (highest priority after reset): clears valid_o, aborts SHIFT/HOLD to IDLE, and blocks acceptance that cycle.

## Timing
- Reset values: valid_o=0, result_o=0, rd_addr_o=0, rd_we_o=0, branch_taken_o=0, state=IDLE. ready_o is 1 in the first cycle after reset is released.
- Reset asserted mid-shift: state returns to IDLE next edge and the partial result is discarded.
- Non-shift latency: 1 cycle (accept edge to valid_o high).
- Iterative shift latency: shamt cycles. ready_o stays low for the duration.
- Output fields hold stable while valid_o && !ready_i.

## Configuration
- ALU_BARREL_SHIFT_EN defined: all shifts complete in 1 cycle like other ops, and the SHIFT/HOLD states are never entered.
- ALU_BARREL_SHIFT_EN undefined: iterative shifter as described, with shamt-cycle latency.

## Structure
- alu_pkg: alu_op_e and alu_src_e (existing), plus new exec_state_e (IDLE, SHIFT, HOLD) and branch funct3 localparams (BR_BEQ … BR_BGEU).
- Sub-module alu_shifter holds the shift datapath and counter, with a start/done interface and the macro switch inside it. execute_stage holds the operand mux, arithmetic/compare, FSM and output register.

## Test plan
- ADD, REG/IMM, rs1=0x0000_0005, imm=0xFFFF_FFFF → result 0x0000_0004, valid_o one cycle after accept.
- SRA, rs1=0x8000_0000, shamt=4, iterative → result 0xF800_0000 after 4 cycles, with ready_o low throughout. With ALU_BARREL_SHIFT_EN, same result in 1 cycle.
- BLT with rs1=0xFFFF_FFFF, rs2=1 → taken=1. BLTU with the same operands → taken=0.
- ready_i held low for 3 cycles with a result pending → outputs stable, ready_o=0. Drain and refill in the same cycle → back-to-back valid with no bubble.
- flush_i during the 2nd cycle of SLL shamt=10 → valid_o=0, IDLE next cycle, next ADD accepted normally.
- rst_ni low mid-shift → all outputs 0 and ready_o=1 the cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types for the execute stage: operation/operand-select enums, FSM states, branch funct3 codes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {SRC_REG, SRC_IMM, SRC_PC, SRC_ZERO} alu_src_e;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} exec_state_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for the execute stage. ALU_BARREL_SHIFT_EN selects a single-cycle barrel
// shifter; otherwise shifts iterate one bit per cycle with a down-counter.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  alu_op_e                  i_op,
  input  logic [XLEN-1:0]          i_operand,
  input  logic [$clog2(XLEN)-1:0]  i_shamt,
  output logic                     o_single,
  output logic [XLEN-1:0]          o_single_result,
  output logic                     o_done,
  output logic [XLEN-1:0]          o_result
);

  localparam int SHW = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN

  logic signed [XLEN-1:0] w_sop;
  logic                   w_unused;

  assign w_sop    = i_operand;
  assign w_unused = ^{clk_i, rst_ni, i_start, i_abort};

  always_comb begin
    case (i_op)
      ALU_SLL: o_single_result = i_operand << i_shamt;
      ALU_SRA: o_single_result = w_sop >>> i_shamt;
      default: o_single_result = i_operand >> i_shamt;
    endcase
  end

  assign o_single = 1'b1;
  assign o_done   = 1'b0;
  assign o_result = '0;

`else

  logic [XLEN-1:0] r_data;
  logic [SHW-1:0]  r_cnt;
  alu_op_e         r_op;
  logic [XLEN-1:0] w_step;

  always_comb begin
    case (r_op)
      ALU_SLL: w_step = {r_data[XLEN-2:0], 1'b0};
      ALU_SRA: w_step = {r_data[XLEN-1], r_data[XLEN-1:1]};
      default: w_step = {1'b0, r_data[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_shamt;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // After the last step the counter sits at zero, so r_data keeps the final value for HOLD.
  always_ff @(posedge clk_i) begin
    if (i_start) begin
      r_data <= i_operand;
      r_op   <= i_op;
    end else if (r_cnt != '0) begin
      r_data <= w_step;
    end
  end

  assign o_single        = (i_shamt == '0);
  assign o_single_result = i_operand;
  assign o_done          = (r_cnt == SHW'(1));
  assign o_result        = o_done ? w_step : r_data;

`endif

endmodule

// File: rtl/execute_stage.sv
// Registered execute stage: operand mux, ALU, branch compare, shift FSM and valid/ready output register.
// Shift implementation is selected by ALU_BARREL_SHIFT_EN (see alu_shifter).
module execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  alu_op_e         alu_op_i,
  input  alu_src_e        alu_src1_i,
  input  alu_src_e        alu_src2_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_branch_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            branch_taken_o
);

  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sel_operand(input alu_src_e src, input logic [XLEN-1:0] reg_v,
                                                  input logic [XLEN-1:0] imm_v, input logic [XLEN-1:0] pc_v);
    case (src)
      SRC_REG: return reg_v;
      SRC_IMM: return imm_v;
      SRC_PC:  return pc_v;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_compute(input alu_op_e op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default:  return '0;
    endcase
  endfunction

  function automatic logic branch_eval(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return sa < sb;
      BR_BGE:  return sa >= sb;
      BR_BLTU: return a < b;
      BR_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  exec_state_e     r_state, w_state_nxt;
  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_addr;
  logic            r_rd_we;
  logic            r_taken;
  logic [4:0]      r_rd_addr_q;
  logic            r_rd_we_q;
  logic            r_taken_q;

  logic [XLEN-1:0] w_op1, w_op2, w_alu_res, w_res_now, w_shift_single_res, w_shift_res;
  logic            w_taken, w_is_shift, w_shift_single, w_single, w_shift_done;
  logic            w_out_free, w_accept, w_start, w_wr_now, w_wr_late;

  assign w_op1     = sel_operand(alu_src1_i, rs1_data_i, imm_i, pc_i);
  assign w_op2     = sel_operand(alu_src2_i, rs2_data_i, imm_i, pc_i);
  assign w_alu_res = alu_compute(alu_op_i, w_op1, w_op2);
  assign w_taken   = is_branch_i && branch_eval(funct3_i, w_op1, w_op2);

  assign w_out_free = !r_valid || ready_i;
  assign ready_o    = (r_state == IDLE) && w_out_free && !flush_i;
  assign w_accept   = valid_i && ready_o;
  assign w_is_shift = is_shift_op(alu_op_i);
  assign w_single   = !w_is_shift || w_shift_single;
  assign w_start    = w_accept && !w_single;
  assign w_wr_now   = w_accept && w_single;
  assign w_res_now  = w_is_shift ? w_shift_single_res : w_alu_res;

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .i_start         (w_start),
    .i_abort         (flush_i),
    .i_op            (alu_op_i),
    .i_operand       (w_op1),
    .i_shamt         (w_op2[SHW-1:0]),
    .o_single        (w_shift_single),
    .o_single_result (w_shift_single_res),
    .o_done          (w_shift_done),
    .o_result        (w_shift_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wr_late   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (flush_i) begin
          w_state_nxt = IDLE;
        end else if (w_shift_done) begin
          w_wr_late   = w_out_free;
          w_state_nxt = w_out_free ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (flush_i) begin
          w_state_nxt = IDLE;
        end else if (w_out_free) begin
          w_wr_late   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Metadata of an iterative shift waits here until its result is written.
  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_rd_addr_q <= rd_addr_i;
      r_rd_we_q   <= rd_we_i;
      r_taken_q   <= w_taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_rd_addr <= '0;
      r_rd_we   <= 1'b0;
      r_taken   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_wr_now) begin
      r_valid   <= 1'b1;
      r_result  <= w_res_now;
      r_rd_addr <= rd_addr_i;
      r_rd_we   <= rd_we_i;
      r_taken   <= w_taken;
    end else if (w_wr_late) begin
      r_valid   <= 1'b1;
      r_result  <= w_shift_res;
      r_rd_addr <= r_rd_addr_q;
      r_rd_we   <= r_rd_we_q;
      r_taken   <= r_taken_q;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o        = r_valid;
  assign result_o       = r_result;
  assign rd_addr_o      = r_rd_addr;
  assign rd_we_o        = r_rd_we;
  assign branch_taken_o = r_taken;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model.
`timescale 1ns/1ps
module tb_execute_stage;
  import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SHIFT_WAIT = 0;
`else
  localparam int SHIFT_WAIT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  alu_op_e     alu_op_i = ALU_ADD;
  alu_src_e    alu_src1_i = SRC_REG;
  alu_src_e    alu_src2_i = SRC_REG;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0, pc_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        is_branch_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        branch_taken_o;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .alu_src1_i(alu_src1_i), .alu_src2_i(alu_src2_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .funct3_i(funct3_i), .is_branch_i(is_branch_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .branch_taken_o(branch_taken_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction semantics straight from the ISA rules.
  function automatic logic [31:0] ref_opnd(input alu_src_e s, input logic [31:0] r,
                                           input logic [31:0] imm, input logic [31:0] pc);
    case (s)
      SRC_REG: return r;
      SRC_IMM: return imm;
      SRC_PC:  return pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic br, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    if (!br) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        tk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mon_a, mon_b;

  // Scoreboard: every accepted instruction must appear once at the output handshake, in order.
  always @(negedge clk) begin
    if (!rst_ni || flush_i) begin
      sb_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        check_val("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_val("sb_result", result_o, mon_e.res);
          check_val("sb_rd_addr", 32'(rd_addr_o), 32'(mon_e.rd));
          check_val("sb_rd_we", 32'(rd_we_o), 32'(mon_e.we));
          check_val("sb_taken", 32'(branch_taken_o), 32'(mon_e.tk));
        end
      end
      if (valid_i && ready_o) begin
        mon_a = ref_opnd(alu_src1_i, rs1_data_i, imm_i, pc_i);
        mon_b = ref_opnd(alu_src2_i, rs2_data_i, imm_i, pc_i);
        mon_e.res = ref_alu(alu_op_i, mon_a, mon_b);
        mon_e.rd  = rd_addr_i;
        mon_e.we  = rd_we_i;
        mon_e.tk  = ref_taken(is_branch_i, funct3_i, mon_a, mon_b);
        sb_q.push_back(mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input alu_op_e op, input alu_src_e s1, input alu_src_e s2,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                           input logic [2:0] f3, input logic br, input logic [4:0] rd, input logic we);
    alu_op_i = op; alu_src1_i = s1; alu_src2_i = s2;
    rs1_data_i = r1; rs2_data_i = r2; imm_i = im; pc_i = 32'h0000_1000;
    funct3_i = f3; is_branch_i = br; rd_addr_i = rd; rd_we_i = we;
    valid_i = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input alu_op_e op, input alu_src_e s1, input alu_src_e s2,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic [2:0] f3, input logic br, input logic [4:0] rd, input logic we);
    bit ok;
    ok = 1'b0;
    set_instr(op, s1, s2, r1, r2, im, f3, br, rd, we);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = ready_o;
      tick();
    end
    valid_i = 1'b0;
    check_val("issue_accepted", 32'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    @(negedge clk);
    check_val("rst_valid_o", 32'(valid_o), 0);
    check_val("rst_result_o", result_o, 0);
    check_val("rst_rd_addr_o", 32'(rd_addr_o), 0);
    check_val("rst_rd_we_o", 32'(rd_we_o), 0);
    check_val("rst_taken_o", 32'(branch_taken_o), 0);
    check_val("rst_ready_o", 32'(ready_o), 1);
    tick();

    ready_i = 1'b1;
    issue(ALU_ADD, SRC_REG, SRC_IMM, 32'h0000_0005, 32'h0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    check_val("add_valid", 32'(valid_o), 1);
    check_val("add_result", result_o, 32'h0000_0004);
    check_val("add_rd_addr", 32'(rd_addr_o), 3);
    check_val("add_rd_we", 32'(rd_we_o), 1);
    tick();

    issue(ALU_SRA, SRC_REG, SRC_IMM, 32'h8000_0000, 32'h0, 32'd4, 3'd0, 1'b0, 5'd4, 1'b1);
    for (int c = 0; c < SHIFT_WAIT; c++) begin
      @(negedge clk);
      check_val("sra_busy_valid", 32'(valid_o), 0);
      check_val("sra_busy_ready", 32'(ready_o), 0);
      tick();
    end
    @(negedge clk);
    check_val("sra_valid", 32'(valid_o), 1);
    check_val("sra_result", result_o, 32'hF800_0000);
    tick();

    issue(ALU_SUB, SRC_REG, SRC_REG, 32'hFFFF_FFFF, 32'h1, 32'h0, BR_BLT, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    check_val("blt_taken", 32'(branch_taken_o), 1);
    tick();
    issue(ALU_SUB, SRC_REG, SRC_REG, 32'hFFFF_FFFF, 32'h1, 32'h0, BR_BLTU, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    check_val("bltu_taken", 32'(branch_taken_o), 0);
    tick();

    ready_i = 1'b0;
    issue(ALU_ADD, SRC_REG, SRC_REG, 32'd10, 32'd20, 32'h0, 3'd0, 1'b0, 5'd7, 1'b1);
    set_instr(ALU_XOR, SRC_REG, SRC_REG, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 3'd0, 1'b0, 5'd8, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("stall_valid", 32'(valid_o), 1);
      check_val("stall_result", result_o, 32'd30);
      check_val("stall_rd_addr", 32'(rd_addr_o), 7);
      check_val("stall_ready_o", 32'(ready_o), 0);
      tick();
    end
    ready_i = 1'b1;
    @(negedge clk);
    check_val("refill_ready_o", 32'(ready_o), 1);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    check_val("refill_valid", 32'(valid_o), 1);
    check_val("refill_result", result_o, 32'h0000_FF00);
    check_val("refill_rd_addr", 32'(rd_addr_o), 8);
    tick();

    issue(ALU_SLL, SRC_REG, SRC_IMM, 32'h1, 32'h0, 32'd10, 3'd0, 1'b0, 5'd5, 1'b1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check_val("flush_valid", 32'(valid_o), 0);
    check_val("flush_ready_o", 32'(ready_o), 1);
    tick();
    issue(ALU_ADD, SRC_REG, SRC_REG, 32'd7, 32'd8, 32'h0, 3'd0, 1'b0, 5'd9, 1'b1);
    @(negedge clk);
    check_val("post_flush_valid", 32'(valid_o), 1);
    check_val("post_flush_result", result_o, 32'd15);
    tick();

    issue(ALU_SRL, SRC_REG, SRC_IMM, 32'hFFFF_0000, 32'h0, 32'd8, 3'd0, 1'b0, 5'd6, 1'b1);
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    check_val("midrst_valid", 32'(valid_o), 0);
    check_val("midrst_result", result_o, 0);
    check_val("midrst_rd_addr", 32'(rd_addr_o), 0);
    check_val("midrst_rd_we", 32'(rd_we_o), 0);
    check_val("midrst_taken", 32'(branch_taken_o), 0);
    check_val("midrst_ready_o", 32'(ready_o), 1);
    tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_val("midrst_discard", 32'(valid_o), 0);
      tick();
    end

    for (int c = 0; c < 600; c++) begin
      alu_op_i    = alu_op_e'($urandom_range(0, 9));
      alu_src1_i  = alu_src_e'($urandom_range(0, 3));
      alu_src2_i  = alu_src_e'($urandom_range(0, 3));
      rs1_data_i  = $urandom;
      rs2_data_i  = ($urandom_range(0, 3) == 0) ? rs1_data_i : $urandom;
      imm_i       = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 6));
      pc_i        = $urandom;
      funct3_i    = 3'($urandom_range(0, 7));
      is_branch_i = 1'($urandom_range(0, 1));
      rd_addr_i   = 5'($urandom_range(0, 31));
      rd_we_i     = 1'($urandom_range(0, 1));
      valid_i     = ($urandom_range(0, 3) != 0);
      ready_i     = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
      tick();
    end

    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 100 && (sb_q.size() != 0 || valid_o); c++) tick();
    check_val("drain_empty", 32'(sb_q.size()), 0);
    check_val("drain_valid", 32'(valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
